// File: rtl/audio_avg_filter_stream.sv
// Streaming moving average over a run-time power-of-two window, kept in a circular history RAM; handshake at T -> out_valid at T+3.
// One sample in flight: in_ready only in IDLE, out_data held until out_ready; a window change flushes the history first.
module audio_avg_filter_stream #(
  parameter int DATA_W        = 8,
  parameter int LOG2_MAX_TAPS = 3,
  parameter int SUM_W         = DATA_W + LOG2_MAX_TAPS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        tap_sel,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              primed,
  output logic              busy_clear
);

  localparam int MAX_TAPS = 1 << LOG2_MAX_TAPS;
  localparam int AW       = LOG2_MAX_TAPS;
  localparam int CW       = LOG2_MAX_TAPS + 1;

  typedef enum logic [2:0] {CLEAR, IDLE, READ, UPDATE, HOLD} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        k_sel;
  logic [3:0]        active_k;
  logic [AW-1:0]     clear_cnt;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_addr;
  logic [CW-1:0]     fill_cnt;
  logic [CW-1:0]     n_taps;
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  sum_nxt;
  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] old;
  logic [DATA_W-1:0] ram [MAX_TAPS];
  logic              ram_we;
  logic [AW-1:0]     ram_wa;
  logic [DATA_W-1:0] ram_wd;
  logic              accept;

  assign k_sel   = (tap_sel > 4'(LOG2_MAX_TAPS)) ? 4'(LOG2_MAX_TAPS) : tap_sel;
  assign n_taps  = CW'(1) << active_k;
  // For a full window the low bits of N are zero, so the slot about to be overwritten is read.
  assign rd_addr = wr_ptr - n_taps[AW-1:0];
  // The window sum always fits, so modular wrap of the intermediate sum+x is harmless.
  assign sum_nxt = sum + SUM_W'(x) - SUM_W'(old);
  assign primed  = !rst && (fill_cnt == n_taps);

  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    busy_clear = 1'b0;
    accept     = 1'b0;
    ram_we     = 1'b0;
    ram_wa     = clear_cnt;
    ram_wd     = '0;
    case (state)
      CLEAR: begin
        busy_clear = 1'b1;
        ram_we     = 1'b1;
        if (clear_cnt == AW'(MAX_TAPS - 1)) state_nxt = IDLE;
      end
      IDLE: begin
        if (k_sel != active_k) begin
          state_nxt = CLEAR;
        end else begin
          in_ready = 1'b1;
          if (in_valid) begin
            accept    = 1'b1;
            state_nxt = READ;
          end
        end
      end
      READ: state_nxt = UPDATE;
      UPDATE: begin
        ram_we    = 1'b1;
        ram_wa    = wr_ptr;
        ram_wd    = x;
        state_nxt = HOLD;
      end
      HOLD: if (out_ready) state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
    if (rst) begin
      in_ready   = 1'b0;
      busy_clear = 1'b1;
      accept     = 1'b0;
      ram_we     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clear_cnt <= '0;
      wr_ptr    <= '0;
      sum       <= '0;
      fill_cnt  <= '0;
      active_k  <= k_sel;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clear_cnt <= clear_cnt + AW'(1);
          wr_ptr    <= '0;
          sum       <= '0;
          fill_cnt  <= '0;
          active_k  <= k_sel;
        end
        IDLE: begin
          if (k_sel != active_k) clear_cnt <= '0;
        end
        UPDATE: begin
          sum       <= sum_nxt;
          wr_ptr    <= wr_ptr + AW'(1);
          fill_cnt  <= (fill_cnt == n_taps) ? fill_cnt : fill_cnt + CW'(1);
          out_data  <= DATA_W'(sum_nxt >> active_k);
          out_valid <= 1'b1;
        end
        HOLD: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // History RAM: synchronous read on accept, single write port shared by flush and update.
  always_ff @(posedge clk) begin
    if (accept) begin
      x   <= in_data;
      old <= ram[rd_addr];
    end
    if (ram_we) ram[ram_wa] <= ram_wd;
  end

endmodule

// File: tb/tb_audio_avg_filter_stream.sv
// Bench for audio_avg_filter_stream: directed vector table, multi-cycle corner sequences, random stimulus vs. window model.
module tb_audio_avg_filter_stream;

  localparam int DATA_W = 8;
  localparam int LOG2   = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        tap_sel;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              primed;
  logic              busy_clear;

  int checks   = 0;
  int failures = 0;
  int model_k;
  int hist[$];

  typedef struct {
    int tap;
    int d;
    int exp;
    int pr;
  } vec_t;
  vec_t vecs[21];

  audio_avg_filter_stream #(.DATA_W(DATA_W), .LOG2_MAX_TAPS(LOG2)) dut (
    .clk(clk), .rst(rst), .tap_sel(tap_sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .primed(primed), .busy_clear(busy_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int clampk(input int t);
    return (t > LOG2) ? LOG2 : t;
  endfunction

  task automatic model_flush(input int t);
    hist.delete();
    model_k = clampk(t);
  endtask

  // Window average with zero padding: sum of the last N accepted samples, floored by N.
  task automatic model_push(input int d, output int exp, output int pr);
    int n;
    int s;
    n = 1 << model_k;
    s = 0;
    hist.push_back(d);
    for (int i = 0; i < n && i < hist.size(); i++) s += hist[hist.size() - 1 - i];
    exp = s >> model_k;
    pr  = (hist.size() >= n) ? 1 : 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_sample(input int d, input int exp, input int exp_pr, input int hold, input string tag);
    int n;
    in_data  = DATA_W'(d);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      cycle();
      n++;
    end
    if (!in_ready) chk($sformatf("%s handshake_timeout", tag), 0, 1);
    cycle();
    in_valid  = 1'b0;
    in_data   = DATA_W'($urandom);
    out_ready = (hold == 0);
    n = 1;
    while (!out_valid && n < 20) begin
      cycle();
      n++;
    end
    chk($sformatf("%s latency", tag), n, 3);
    chk($sformatf("%s out_data", tag), int'(out_data), exp);
    chk($sformatf("%s primed", tag), int'(primed), exp_pr);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(~d);
      cycle();
      chk($sformatf("%s hold out_valid", tag), int'(out_valid), 1);
      chk($sformatf("%s hold out_data", tag), int'(out_data), exp);
      chk($sformatf("%s hold in_ready", tag), int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic change_tap(input int t);
    int n;
    int bad;
    bit diff;
    cycle();
    diff    = (clampk(t) != clampk(int'(tap_sel)));
    tap_sel = 4'(t);
    #1;
    if (diff) begin
      chk($sformatf("tap%0d in_ready on change", t), int'(in_ready), 0);
      n   = 0;
      bad = 0;
      for (int i = 0; i < 30; i++) begin
        cycle();
        if (!busy_clear) break;
        n++;
        if (in_ready) bad++;
      end
      chk($sformatf("tap%0d busy_clear cycles", t), n, 8);
      chk($sformatf("tap%0d in_ready during clear", t), bad, 0);
      model_flush(t);
    end else begin
      chk($sformatf("tap%0d same window no flush", t), int'(in_ready), 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    int d;
    int e;
    int p;

    vecs[0]  = '{2, 4, 1, 0};    vecs[1]  = '{2, 8, 3, 0};
    vecs[2]  = '{2, 12, 6, 0};   vecs[3]  = '{2, 16, 10, 1};
    vecs[4]  = '{2, 20, 14, 1};
    vecs[5]  = '{0, 200, 200, 1}; vecs[6] = '{0, 7, 7, 1};
    vecs[7]  = '{0, 0, 0, 1};    vecs[8]  = '{0, 255, 255, 1};
    vecs[9]  = '{3, 255, 31, 0};  vecs[10] = '{3, 255, 63, 0};
    vecs[11] = '{3, 255, 95, 0};  vecs[12] = '{3, 255, 127, 0};
    vecs[13] = '{3, 255, 159, 0}; vecs[14] = '{3, 255, 191, 0};
    vecs[15] = '{3, 255, 223, 0}; vecs[16] = '{3, 255, 255, 1};
    vecs[17] = '{3, 0, 223, 1};
    vecs[18] = '{1, 10, 5, 0};   vecs[19] = '{1, 20, 15, 1};
    vecs[20] = '{1, 30, 25, 1};

    rst       = 1'b1;
    tap_sel   = 4'd2;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) cycle();
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_data", int'(out_data), 0);
    chk("reset in_ready", int'(in_ready), 0);
    chk("reset primed", int'(primed), 0);
    chk("reset busy_clear", int'(busy_clear), 1);
    rst = 1'b0;
    model_flush(2);
    #1;
    n = 0;
    while (!in_ready && n < 30) begin
      n++;
      cycle();
    end
    chk("post-reset in_ready low cycles", n, 8);

    for (int i = 0; i < 21; i++) begin
      if (vecs[i].tap != int'(tap_sel)) change_tap(vecs[i].tap);
      do_sample(vecs[i].d, vecs[i].exp, vecs[i].pr, 0, $sformatf("vec%0d", i));
    end

    // tap_sel above the maximum clamps to the full window; one sample is held off for 5 cycles.
    change_tap(9);
    for (int i = 0; i < 10; i++) begin
      d = int'($urandom_range(0, 255));
      model_push(d, e, p);
      do_sample(d, e, p, (i == 4) ? 5 : 0, $sformatf("clamp%0d", i));
    end

    // Reset while in READ aborts the sample and reflushes.
    change_tap(2);
    in_data  = 8'd77;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      cycle();
      n++;
    end
    cycle();
    in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk("rst-in-read out_valid", int'(out_valid), 0);
    chk("rst-in-read busy_clear", int'(busy_clear), 1);
    n   = 0;
    bad = 0;
    while (!in_ready && n < 30) begin
      if (out_valid) bad++;
      n++;
      cycle();
    end
    chk("rst-in-read clear cycles", n, 8);
    chk("rst-in-read no partial output", bad, 0);
    model_flush(2);
    model_push(40, e, p);
    chk("model 40 after flush", e, 10);
    do_sample(40, 10, 0, 0, "post-rst 40");

    for (int r = 0; r < 6; r++) begin
      change_tap(int'($urandom_range(0, 15)));
      for (int j = 0; j < 11; j++) begin
        d = int'($urandom_range(0, 255));
        model_push(d, e, p);
        do_sample(d, e, p, int'($urandom_range(0, 3)), $sformatf("rnd%0d_%0d", r, j));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
